// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, response tag and address legality check for the data-memory arbiter
package dmem_pkg;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   // One entry of the in-flight response pipeline.
   typedef struct packed {
      logic valid;
      logic owner;
      logic is_read;
      logic err;
   } tag_t;

   // A byte address is legal when it is word aligned and falls inside the
   // 2**addr_w word memory, i.e. no bit above addr[addr_w+1] is set.
   function automatic logic addr_legal(input logic [31:0] addr, input int unsigned addr_w);
      logic [31:0] hi_mask;
      hi_mask = ~((32'd1 << (addr_w + 32'd2)) - 32'd1);
      return (addr[1:0] == 2'b00) && ((addr & hi_mask) == 32'd0);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with one-hot grant
module rr_arb2
   import dmem_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // Most recently granted port; starts at the DMA so the CPU wins the first tie.
   logic last;

   // Grant a lone requester directly; on a tie the port that was not last wins.
   always_comb begin
      gnt = 2'b00;
      if (!reset) begin
         if (req[0] && req[1]) begin
            if (last == PORT_CPU) gnt = 2'b10;
            else                  gnt = 2'b01;
         end else begin
            gnt = req;
         end
      end
   end

   // Pointer moves only when something was actually granted.
   always_ff @(posedge clk) begin
      if (reset)      last <= PORT_DMA;
      else if (|gnt)  last <= gnt[1];
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin sharing of the data memory between CPU and DMA with tagged read return
module data_mem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [31:0]       addr0,
   input  logic [31:0]       addr1,
   input  logic [31:0]       wdata0,
   input  logic [31:0]       wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic              err0,
   output logic              err1,
   output logic [31:0]       rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   logic [1:0]  gnt_vec;
   logic        any_gnt;
   logic        sel;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        legal;
   tag_t        tag_in;
   tag_t        tail;
   logic        rsp_ok;

   // Tag pipeline: stage 0 is loaded at the grant edge, the last stage lines up
   // with mem_rdata RD_LATENCY cycles after the registered command.
   tag_t pipe [0:RD_LATENCY];

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({req1, req0}),
      .gnt   (gnt_vec)
   );

   assign gnt0    = gnt_vec[0];
   assign gnt1    = gnt_vec[1];
   assign any_gnt = |gnt_vec;

   // Steer the winning port's request fields.
   assign sel       = gnt_vec[1];
   assign sel_we    = sel ? we1    : we0;
   assign sel_addr  = sel ? addr1  : addr0;
   assign sel_wdata = sel ? wdata1 : wdata0;
   assign legal     = addr_legal(sel_addr, ADDR_W);

   assign tag_in = '{valid: any_gnt, owner: sel, is_read: ~sel_we, err: ~legal};

   // Command registers: strobes last one cycle per legal grant, address/data hold otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_read  <= any_gnt && legal && !sel_we;
         mem_write <= any_gnt && legal &&  sel_we;
         if (any_gnt && legal) begin
            mem_addr  <= sel_addr[ADDR_W+1:2];
            mem_wdata <= sel_wdata;
         end
      end
   end

   // Shift every granted request's tag toward the response point; reset drops all in-flight tags.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i <= RD_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= tag_in;
         for (int i = 1; i <= RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign tail   = pipe[RD_LATENCY];
   assign rsp_ok = tail.valid && !reset;

   assign rvalid0 = rsp_ok && tail.is_read && !tail.err && (tail.owner == PORT_CPU);
   assign rvalid1 = rsp_ok && tail.is_read && !tail.err && (tail.owner == PORT_DMA);
   assign err0    = rsp_ok && tail.err && (tail.owner == PORT_CPU);
   assign err1    = rsp_ok && tail.err && (tail.owner == PORT_DMA);
   assign rdata   = (rvalid0 || rvalid1) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter at read latency 1 and 3
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;

   logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, err0_a, err1_a;
   logic [31:0] rdata_a, mem_wdata_a, mem_rdata_a;
   logic        mem_read_a, mem_write_a;
   logic [9:0]  mem_addr_a;

   logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, err0_b, err1_b;
   logic [31:0] rdata_b, mem_wdata_b, mem_rdata_b;
   logic        mem_read_b, mem_write_b;
   logic [9:0]  mem_addr_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.ADDR_W(10), .RD_LATENCY(1)) dut_a (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0_a), .gnt1(gnt1_a), .rvalid0(rvalid0_a), .rvalid1(rvalid1_a),
      .err0(err0_a), .err1(err1_a), .rdata(rdata_a),
      .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
   );

   data_mem_arbiter #(.ADDR_W(10), .RD_LATENCY(3)) dut_b (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
      .err0(err0_b), .err1(err1_b), .rdata(rdata_b),
      .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
   );

   // Memory models: latency 1 and latency 3 single-port RAMs.
   logic [31:0] mem_a [0:1023];
   logic [31:0] mem_b [0:1023];
   logic [31:0] rq_a;
   logic [31:0] s1_b, s2_b, s3_b;

   always @(posedge clk) begin
      if (mem_write_a) mem_a[mem_addr_a] = mem_wdata_a;
      if (mem_read_a)  rq_a <= mem_a[mem_addr_a];
   end
   assign mem_rdata_a = rq_a;

   always @(posedge clk) begin
      if (mem_write_b) mem_b[mem_addr_b] = mem_wdata_b;
      s1_b <= mem_read_b ? mem_b[mem_addr_b] : 32'd0;
      s2_b <= s1_b;
      s3_b <= s2_b;
   end
   assign mem_rdata_b = s3_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1; idle();
      next_cycle(); next_cycle();
      reset = 0;
   endtask

   logic [31:0] words [0:3];

   initial begin
      words[0] = 32'h12345678; words[1] = 32'hA5A50005;
      words[2] = 32'h66660006; words[3] = 32'h77770007;
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = 32'd0; mem_b[i] = 32'd0;
      end
      for (int i = 0; i < 4; i++) begin
         mem_a[4+i] = words[i]; mem_b[4+i] = words[i];
      end
      rq_a = 0; s1_b = 0; s2_b = 0; s3_b = 0;

      // Reset values
      reset = 1; idle();
      next_cycle();
      req0 = 1; req1 = 1;
      @(negedge clk);
      chk("rst_gnt",  {30'd0, gnt1_a, gnt0_a}, 32'd0);
      chk("rst_rsp",  {28'd0, rvalid1_a, rvalid0_a, err1_a, err0_a}, 32'd0);
      chk("rst_cmd",  {30'd0, mem_write_a, mem_read_a}, 32'd0);
      chk("rst_addr", {22'd0, mem_addr_a}, 32'd0);
      chk("rst_wd",   mem_wdata_a, 32'd0);
      chk("rst_rd",   rdata_a, 32'd0);
      next_cycle();
      reset = 0; idle();

      // Single read, both latencies
      next_cycle();
      req0 = 1; addr0 = 32'h10;
      @(negedge clk);
      chk("sr_gnt", {30'd0, gnt1_a, gnt0_a}, 32'd1);
      next_cycle(); idle();
      @(negedge clk);
      chk("sr_mread", {31'd0, mem_read_a}, 32'd1);
      chk("sr_maddr", {22'd0, mem_addr_a}, 32'd4);
      chk("sr_early", {31'd0, rvalid0_a}, 32'd0);
      chk("sr_mread_b", {31'd0, mem_read_b}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("sr_rvalid", {30'd0, rvalid1_a, rvalid0_a}, 32'd1);
      chk("sr_rdata",  rdata_a, 32'h12345678);
      chk("sr_cmd_off", {31'd0, mem_read_a}, 32'd0);
      chk("sr_b_t2", {31'd0, rvalid0_b}, 32'd0);
      next_cycle();
      @(negedge clk);
      chk("sr_rv_off", {31'd0, rvalid0_a}, 32'd0);
      chk("sr_b_t3", {31'd0, rvalid0_b}, 32'd0);
      next_cycle();
      @(negedge clk);
      chk("sr_b_rvalid", {30'd0, rvalid1_b, rvalid0_b}, 32'd1);
      chk("sr_b_rdata",  rdata_b, 32'h12345678);

      // Tie-break: continuous dual reads for 4 cycles from fresh reset
      do_reset();
      for (int k = 0; k < 6; k++) begin
         if (k > 0) next_cycle();
         if (k < 4) begin
            req0 = 1; addr0 = 32'h10;
            req1 = 1; addr1 = 32'h14;
         end else idle();
         @(negedge clk);
         chk($sformatf("tie_gnt%0d", k), {30'd0, gnt1_a, gnt0_a},
             (k >= 4) ? 32'd0 : ((k % 2 == 0) ? 32'd1 : 32'd2));
         if (k >= 2) begin
            chk($sformatf("tie_rv%0d", k), {30'd0, rvalid1_a, rvalid0_a},
                (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("tie_rd%0d", k), rdata_a,
                (k % 2 == 0) ? 32'h12345678 : 32'hA5A50005);
         end
      end

      // Write then read from port 1
      next_cycle();
      req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'hDEADBEEF;
      @(negedge clk);
      chk("wr_gnt", {30'd0, gnt1_a, gnt0_a}, 32'd2);
      next_cycle();
      we1 = 0; wdata1 = 0;
      @(negedge clk);
      chk("wr_cmd",   {30'd0, mem_write_a, mem_read_a}, 32'd2);
      chk("wr_maddr", {22'd0, mem_addr_a}, 32'd8);
      chk("wr_mwd",   mem_wdata_a, 32'hDEADBEEF);
      chk("rd_gnt",   {30'd0, gnt1_a, gnt0_a}, 32'd2);
      next_cycle(); idle();
      @(negedge clk);
      chk("wr_norsp", {28'd0, rvalid1_a, rvalid0_a, err1_a, err0_a}, 32'd0);
      chk("rd_cmd",   {30'd0, mem_write_a, mem_read_a}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("rd_rv",    {30'd0, rvalid1_a, rvalid0_a}, 32'd2);
      chk("rd_data",  rdata_a, 32'hDEADBEEF);

      // Misaligned read from port 0
      next_cycle();
      req0 = 1; addr0 = 32'h13;
      @(negedge clk);
      chk("mis_gnt", {30'd0, gnt1_a, gnt0_a}, 32'd1);
      next_cycle(); idle();
      @(negedge clk);
      chk("mis_cmd", {30'd0, mem_write_a, mem_read_a}, 32'd0);
      next_cycle();
      @(negedge clk);
      chk("mis_rsp", {28'd0, rvalid1_a, rvalid0_a, err1_a, err0_a}, 32'd1);

      // Out-of-range write from port 1
      next_cycle();
      req1 = 1; we1 = 1; addr1 = 32'h00001000; wdata1 = 32'h0BADF00D;
      @(negedge clk);
      chk("oor_gnt", {30'd0, gnt1_a, gnt0_a}, 32'd2);
      next_cycle(); idle();
      @(negedge clk);
      chk("oor_cmd", {30'd0, mem_write_a, mem_read_a}, 32'd0);
      next_cycle();
      @(negedge clk);
      chk("oor_rsp", {28'd0, rvalid1_a, rvalid0_a, err1_a, err0_a}, 32'd2);

      // Reset while a read is in flight
      next_cycle();
      req0 = 1; addr0 = 32'h10;
      @(negedge clk);
      chk("mr_gnt", {30'd0, gnt1_a, gnt0_a}, 32'd1);
      next_cycle(); idle(); reset = 1;
      next_cycle(); reset = 0;
      @(negedge clk);
      chk("mr_rsp",  {28'd0, rvalid1_a, rvalid0_a, err1_a, err0_a}, 32'd0);
      chk("mr_cmd",  {30'd0, mem_write_a, mem_read_a}, 32'd0);
      chk("mr_addr", {22'd0, mem_addr_a}, 32'd0);
      chk("mr_rd",   rdata_a, 32'd0);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         @(negedge clk);
         chk($sformatf("mr_b%0d", k), {28'd0, rvalid1_b, rvalid0_b, err1_b, err0_b}, 32'd0);
      end
      // Pointer restored: first tie goes to the CPU
      next_cycle();
      req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h14;
      @(negedge clk);
      chk("mr_tie", {30'd0, gnt1_a, gnt0_a}, 32'd1);
      next_cycle(); idle();
      next_cycle(); next_cycle(); next_cycle(); next_cycle();

      // Back-to-back reads: latency 1 returns at k=2..5, latency 3 at k=4..7
      for (int k = 0; k < 9; k++) begin
         if (k > 0) next_cycle();
         if (k < 4) begin
            req0 = 1; addr0 = 32'h10 + 32'(k * 4);
         end else idle();
         @(negedge clk);
         if (k < 4) chk($sformatf("b2b_gnt%0d", k), {30'd0, gnt1_b, gnt0_b}, 32'd1);
         chk($sformatf("b2b_a_rv%0d", k), {31'd0, rvalid0_a}, (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
         if (k >= 2 && k <= 5) chk($sformatf("b2b_a_rd%0d", k), rdata_a, words[k-2]);
         chk($sformatf("b2b_b_rv%0d", k), {31'd0, rvalid0_b}, (k >= 4 && k <= 7) ? 32'd1 : 32'd0);
         if (k >= 4 && k <= 7) chk($sformatf("b2b_b_rd%0d", k), rdata_b, words[k-4]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port data memory between two requesters: port 0 is the CPU load/store stage, port 1 is the peripheral DMA engine. Each cycle it grants at most one request by round-robin and issues one registered command to the memory. Read data is routed back to the owning port through an in-flight tag pipeline. It sits between the requesters and the data memory. Its `mem_*` outputs are the natural tap point for the data-memory print monitor.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width of the memory (1024 words).
- `RD_LATENCY`, 1: cycles from a registered `mem_read` to valid `mem_rdata`; legal range 1..4.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  request valid, per port.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  32  byte address.
- `wdata0`, `wdata1`  in  32  write data.
- `gnt0`, `gnt1`  out  1  combinational; request accepted this cycle.
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse; `rdata` is valid for this port.
- `err0`, `err1`  out  1  one-cycle pulse; the request was rejected.
- `rdata`  out  32  read data, shared by both ports; qualify with `rvalid*`.
- `mem_read`, `mem_write`  out  1  registered memory command.
- `mem_addr`  out  ADDR_W  registered word address, taken from `addr[ADDR_W+1:2]`.
- `mem_wdata`  out  32  registered write data.
- `mem_rdata`  in  32  memory read data.

## Operation
- **Arbitration.** A 1-bit `last` pointer records the most recently granted port.
  - If only one port requests, that port is granted.
  - If both request, the port that is not `last` wins.
  - `last` updates only on a grant.
  - After reset, `last` = 1, so the CPU wins the first tie.
- **Accept rule.** A request is accepted in the cycle its `gnt` is high. The requester must hold `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. At most one grant is issued per cycle, and there is no backpressure from memory.
- **Legality check.** An accepted request is illegal if `addr[1:0] != 0` or if any bit of `addr[31:ADDR_W+2]` is set.
  - An illegal request is granted but never reaches memory: `mem_read` and `mem_write` stay 0.
- **Command stage.** A legal grant loads the `mem_*` registers on the next edge. The command stays high for exactly one cycle unless another grant follows immediately.
- **Tag pipeline.** A shift register `RD_LATENCY+1` deep carries `{valid, owner, is_read, err}` for every granted request, legal or illegal.
  - When a tag exits the pipeline:
    - legal read: pulse `rvalid[owner]`, with `rdata = mem_rdata`;
    - legal write: no response;
    - illegal request (read or write): pulse `err[owner]` with `rvalid` = 0.
- **Reset mid-operation.** All tags are cleared. No `rvalid` or `err` may appear for requests accepted before reset. A memory write already registered completes in the reset cycle; that is acceptable.
- **Reset values.** The following are all 0: `gnt*`, `rvalid*`, `err*`, `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `rdata`. `last` resets to 1.

## Timing
- `gnt` is combinational from `req*` and `last` in cycle T.
- The memory command is visible in cycle T+1.
- `rvalid` or `err` fires in cycle T+1+`RD_LATENCY`; the default is T+2.
- Throughput: one accepted request per cycle sustained. Back-to-back grants produce back-to-back responses in order.
- Alternating grants under continuous dual requests: 0,1,0,1…
- Both ports may receive `rvalid` in consecutive cycles. They never receive it in the same cycle.

## Structure
- Shared package `dmem_pkg`:
  - port-index constants `PORT_CPU`=0 and `PORT_DMA`=1;
  - the tag struct `{valid, owner, is_read, err}`;
  - the legality-check function.
- One sub-module, `rr_arb2`: a two-input round-robin arbiter holding the `last` pointer, with a grant-one-hot output.
- The tag pipeline and the command registers stay in the top level.

## Test plan
- **Single read.** Reset, then `req0=1`, `we0=0`, `addr0=0x10` with memory word 4 = `0x12345678`. Expect `gnt0` at T, `mem_read=1` with `mem_addr=4` at T+1, and `rvalid0=1` with `rdata=0x12345678` at T+2.
- **Tie-break.** Both ports request reads continuously for 4 cycles. Expect grants 0,1,0,1 and `rvalid` pulses in the same order 2 cycles later, never both in one cycle.
- **Write then read.** Port 1 writes `0xDEADBEEF` to `0x20`, then reads `0x20`. Expect `mem_write` at T+1 with `mem_addr=8`, no response for the write, and the read returns `0xDEADBEEF`.
- **Illegal addresses.**
  - Port 0 reads `0x13` (misaligned): expect `gnt0`, no memory command, and `err0` at T+2.
  - Port 1 writes `0x00001000` with `ADDR_W=10` (out of range): expect `err1` at T+2.
- **Reset mid-flight.** Grant a read at T and assert `reset` at T+1. Expect no `rvalid0` at T+2 and every output at its reset value after the edge.
- **Longer latency.** Repeat the single-read case with `RD_LATENCY=3`. Expect `rvalid0` at T+4, and 4 back-to-back reads to return in order at T+4..T+7.
